vram_arbiter: RTL



---
 rtl/vram_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - per-cycle VRAM arbiter: renderer priority, posted MPU writes, single MPU read
module vram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_STALL  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ren_req,
    input  logic [ADDR_WIDTH-1:0] ren_addr,
    output logic                  ren_grant,
    output logic                  ren_valid,
    output logic [DATA_WIDTH-1:0] ren_data,
    input  logic                  mpu_wr,
    input  logic                  mpu_rd,
    input  logic [ADDR_WIDTH-1:0] mpu_addr,
    input  logic [1:0]            mpu_be,
    input  logic [DATA_WIDTH-1:0] mpu_wdata,
    output logic                  mpu_full,
    output logic                  mpu_busy,
    output logic                  mpu_rvalid,
    output logic [DATA_WIDTH-1:0] mpu_rdata,
    output logic                  vram_en,
    output logic                  vram_rd,
    output logic                  vram_wr,
    output logic [1:0]            vram_be,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_data_out,
    input  logic [DATA_WIDTH-1:0] vram_data_in
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_STALL + 1);
    localparam int EW = ADDR_WIDTH + 2 + DATA_WIDTH;

    logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [SW-1:0]         stall_q, stall_d;
    logic [1:0]            tag_q, tag_d;

    logic                  vram_en_q, vram_en_d, vram_rd_q, vram_rd_d, vram_wr_q, vram_wr_d;
    logic [1:0]            vram_be_q, vram_be_d;
    logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
    logic [DATA_WIDTH-1:0] vram_data_q, vram_data_d;
    logic                  ren_valid_q, mpu_rvalid_q;
    logic [DATA_WIDTH-1:0] ren_data_q, mpu_rdata_q;

    logic                  fifo_empty, fifo_full, force_mpu, mpu_work, push;
    logic                  sel_ren, sel_fifo, sel_rd;
    logic [EW-1:0]         head;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign force_mpu  = (stall_q == SW'(MAX_STALL));
    assign mpu_work   = !fifo_empty || rd_pend_q;
    assign head       = fifo_mem[rd_ptr_q];
    // A full FIFO still accepts a write when its head drains in the same cycle.
    assign push       = mpu_wr && (!fifo_full || sel_fifo);

    always_comb begin
        sel_ren  = 1'b0;
        sel_fifo = 1'b0;
        sel_rd   = 1'b0;
        if (force_mpu) begin
            if (!fifo_empty)    sel_fifo = 1'b1;
            else if (rd_pend_q) sel_rd   = 1'b1;
        end else if (ren_req) begin
            sel_ren = 1'b1;
        end else if (!fifo_empty) begin
            sel_fifo = 1'b1;
        end else if (rd_pend_q) begin
            sel_rd = 1'b1;
        end
    end

    always_comb begin
        wr_ptr_d  = push     ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = sel_fifo ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !sel_fifo)      count_d = count_q + CW'(1);
        else if (!push && sel_fifo) count_d = count_q - CW'(1);

        rd_pend_d = rd_pend_q;
        rd_addr_d = rd_addr_q;
        if (sel_rd) begin
            rd_pend_d = 1'b0;
        end else if (mpu_rd && !rd_pend_q && !tag_q[1]) begin
            rd_pend_d = 1'b1;
            rd_addr_d = mpu_addr;
        end

        stall_d = stall_q;
        if (!mpu_work || sel_fifo || sel_rd) stall_d = '0;
        else if (!force_mpu)                 stall_d = stall_q + SW'(1);

        tag_d       = {sel_rd, sel_ren};
        vram_en_d   = sel_ren || sel_fifo || sel_rd;
        vram_rd_d   = sel_ren || sel_rd;
        vram_wr_d   = sel_fifo;
        vram_be_d   = sel_fifo ? head[DATA_WIDTH +: 2] : (vram_rd_d ? 2'b11 : 2'b00);
        vram_addr_d = vram_addr_q;
        vram_data_d = vram_data_q;
        if (sel_ren) begin
            vram_addr_d = ren_addr;
        end else if (sel_fifo) begin
            vram_addr_d = head[EW-1 -: ADDR_WIDTH];
            vram_data_d = head[DATA_WIDTH-1:0];
        end else if (sel_rd) begin
            vram_addr_d = rd_addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {mpu_addr, mpu_be, mpu_wdata};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            stall_q      <= '0;
            tag_q        <= '0;
            vram_en_q    <= 1'b0;
            vram_rd_q    <= 1'b0;
            vram_wr_q    <= 1'b0;
            vram_be_q    <= '0;
            vram_addr_q  <= '0;
            vram_data_q  <= '0;
            ren_valid_q  <= 1'b0;
            mpu_rvalid_q <= 1'b0;
            ren_data_q   <= '0;
            mpu_rdata_q  <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_pend_q    <= rd_pend_d;
            rd_addr_q    <= rd_addr_d;
            stall_q      <= stall_d;
            tag_q        <= tag_d;
            vram_en_q    <= vram_en_d;
            vram_rd_q    <= vram_rd_d;
            vram_wr_q    <= vram_wr_d;
            vram_be_q    <= vram_be_d;
            vram_addr_q  <= vram_addr_d;
            vram_data_q  <= vram_data_d;
            // tag_q names the owner of the read whose data is on vram_data_in now
            ren_valid_q  <= tag_q[0];
            mpu_rvalid_q <= tag_q[1];
            if (tag_q[0]) ren_data_q  <= vram_data_in;
            if (tag_q[1]) mpu_rdata_q <= vram_data_in;
        end
    end

    assign ren_grant     = ren_req && !force_mpu;
    assign ren_valid     = ren_valid_q;
    assign ren_data      = ren_data_q;
    assign mpu_full      = fifo_full;
    assign mpu_busy      = mpu_work || tag_q[1];
    assign mpu_rvalid    = mpu_rvalid_q;
    assign mpu_rdata     = mpu_rdata_q;
    assign vram_en       = vram_en_q;
    assign vram_rd       = vram_rd_q;
    assign vram_wr       = vram_wr_q;
    assign vram_be       = vram_be_q;
    assign vram_addr     = vram_addr_q;
    assign vram_data_out = vram_data_q;
endmodule
